// File: rtl/prog_loader.sv
// Program loader: streams instruction words into instruction memory while holding the core in reset.
// Optional running checksum of accepted words is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int HOLD_CYC = 2
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              load_start,
  input  logic [63:0]       load_base,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [63:0]       imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              proc_resetl,
  output logic [63:0]       startpc,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  localparam int MAX_WORDS = 1 << ADDR_W;
  // One extra bit so the counter can hold MAX_WORDS itself.
  localparam int CNT_W     = ADDR_W + 1;
  localparam int HOLD_W    = $clog2(HOLD_CYC + 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic [63:0]       base;
  logic [HOLD_W-1:0] hold_cnt;
  logic              beat;
  logic              base_ok;
  logic              start_ok;

  assign beat      = in_valid & in_ready;
  assign count_inc = count + CNT_W'(1);
  assign base_ok   = (load_base[1:0] == 2'b00);
  assign start_ok  = load_start && base_ok && (state == IDLE || state == RUN);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= IDLE;
      count       <= '0;
      base        <= '0;
      hold_cnt    <= '0;
      in_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      proc_resetl <= 1'b0;
      startpc     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values,
      // so the write pipeline and the FSM below see the same beat regardless of order.
      imem_we <= beat;
      done    <= 1'b0;
      if (beat) begin
        imem_addr  <= base + (64'(count) << 2);
        imem_wdata <= in_data;
      end

      case (state)
        IDLE, RUN: begin
          if (load_start) begin
            proc_resetl <= 1'b0;
            if (base_ok) begin
              base     <= load_base;
              count    <= '0;
              err      <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= LOAD;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end
        end

        LOAD: begin
          if (beat) begin
            count <= count_inc;
            if (in_last) begin
              in_ready <= 1'b0;
              hold_cnt <= '0;
              state    <= HOLD;
            end else if (count_inc == CNT_W'(MAX_WORDS)) begin
              // Memory is full and the program has not ended: abandon the session.
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        HOLD: begin
          // hold_cnt==0 is the final write cycle; release after HOLD_CYC further cycles.
          if (hold_cnt == HOLD_W'(HOLD_CYC)) begin
            proc_resetl <= 1'b1;
            startpc     <= base;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= RUN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (beat) begin
      checksum <= checksum + 32'(in_data);
    end
  end
`else
  assign checksum = '0;
`endif

  a_we_follows_beat: assert property (@(posedge CLK) disable iff (!resetl)
    imem_we |-> $past(beat));
  a_done_single: assert property (@(posedge CLK) disable iff (!resetl)
    done |=> !done);
  a_run_not_busy: assert property (@(posedge CLK) disable iff (!resetl)
    proc_resetl |-> !busy);
  a_ready_in_load: assert property (@(posedge CLK) disable iff (!resetl)
    in_ready |-> (state == LOAD));

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a transaction-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_prog_loader;

  localparam int MAX_WORDS = 64;
  localparam int HOLD_CYC  = 2;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        load_start;
  logic [63:0] load_base;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        proc_resetl;
  logic [63:0] startpc;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  prog_loader dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .load_start (load_start),
    .load_base  (load_base),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .proc_resetl(proc_resetl),
    .startpc    (startpc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: session phase flags, word count, base and the absolute edge of release.
  longint      edge_no   = 0;
  bit          m_loading = 0;
  bit          m_holding = 0;
  bit          m_ready   = 0;
  int          m_cnt     = 0;
  logic [63:0] m_base    = '0;
  longint      m_release = 0;
  bit          e_we      = 0;
  logic [63:0] e_addr    = '0;
  logic [31:0] e_wdata   = '0;
  bit          e_prl     = 0;
  logic [63:0] e_startpc = '0;
  bit          e_busy    = 0;
  bit          e_done    = 0;
  bit          e_err     = 0;
  logic [31:0] e_sum     = '0;

  // Monitor statistics, cumulative so scenarios work with deltas.
  int          cyc         = 0;
  int          we_total    = 0;
  int          done_total  = 0;
  int          last_we_cyc = 0;
  int          rise_cyc    = 0;
  bit          prl_d       = 0;
  logic [63:0] last_addr   = '0;
  logic [31:0] last_data   = '0;

  logic [31:0] prog_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_loading = 0; m_holding = 0; m_ready = 0; m_cnt = 0; m_base = '0;
    e_we = 0; e_addr = '0; e_wdata = '0; e_prl = 0; e_startpc = '0;
    e_busy = 0; e_done = 0; e_err = 0; e_sum = '0;
  endtask

  task automatic model_proc();
    bit beat;
    forever begin
      @(posedge CLK or negedge resetl);
      if (!resetl) begin
        model_reset();
      end else begin
        edge_no++;
        beat   = m_ready && in_valid;
        e_we   = beat;
        e_done = 0;
        if (beat) begin
          e_addr  = m_base + 64'(m_cnt) * 4;
          e_wdata = in_data;
          e_sum   = e_sum + in_data;
        end
        if (m_loading) begin
          if (beat) begin
            m_cnt++;
            if (in_last) begin
              m_loading = 0;
              m_holding = 1;
              m_release = edge_no + 1 + HOLD_CYC;
            end else if (m_cnt == MAX_WORDS) begin
              m_loading = 0;
              e_err     = 1;
            end
          end
        end else if (m_holding) begin
          if (edge_no == m_release) begin
            m_holding = 0;
            e_prl     = 1;
            e_startpc = m_base;
            e_done    = 1;
          end
        end else if (load_start) begin
          e_prl = 0;
          if (load_base[1:0] != 2'b00) begin
            e_err = 1;
          end else begin
            e_err     = 0;
            m_base    = load_base;
            m_cnt     = 0;
            m_loading = 1;
            e_sum     = '0;
          end
        end
        m_ready = m_loading && (m_cnt < MAX_WORDS);
        e_busy  = m_loading || m_holding;
      end
    end
  endtask

  task automatic monitor_proc();
    logic [31:0] exp_ck;
    forever begin
      @(negedge CLK);
      cyc++;
`ifdef PROG_LOADER_CHECKSUM_EN
      exp_ck = e_sum;
`else
      exp_ck = 32'h0;
`endif
      check("in_ready", in_ready, m_ready);
      check("imem_we", imem_we, e_we);
      check("imem_addr", imem_addr, e_addr);
      check("imem_wdata", imem_wdata, e_wdata);
      check("proc_resetl", proc_resetl, e_prl);
      check("startpc", startpc, e_startpc);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("err", err, e_err);
      check("checksum", checksum, exp_ck);
      if (imem_we) begin
        we_total++;
        last_we_cyc = cyc;
        last_addr   = imem_addr;
        last_data   = imem_wdata;
      end
      if (done) done_total++;
      if (proc_resetl && !prl_d) rise_cyc = cyc;
      prl_d = proc_resetl;
    end
  endtask

  task automatic start_load(input logic [63:0] base);
    load_start = 1'b1;
    load_base  = base;
    @(negedge CLK);
    load_start = 1'b0;
  endtask

  // Offers n words from prog_q; gap inserts an idle cycle after each accepted word.
  task automatic stream(input int n, input bit gap, input bit mark_last);
    bit ok;
    bit ready_now;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = prog_q[i];
      in_last  = mark_last && (i == n - 1);
      ok = 0;
      for (int w = 0; w < 50; w++) begin
        ready_now = in_ready;
        @(negedge CLK);
        if (ready_now) begin
          ok = 1;
          break;
        end
      end
      check("in_ready wait", ok, 1'b1);
      if (!ok) break;
      if (gap) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge CLK);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int we0;
    int d0;
    resetl     = 1'b0;
    load_start = 1'b0;
    load_base  = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    fork
      model_proc();
      monitor_proc();
    join_none

    repeat (3) @(negedge CLK);
    check("rst proc_resetl", proc_resetl, 1'b0);
    check("rst in_ready", in_ready, 1'b0);
    check("rst err", err, 1'b0);
    resetl = 1'b1;
    repeat (2) @(negedge CLK);

    // Twelve words at base 0, continuous valid.
    prog_q.delete();
    for (int i = 0; i < 12; i++) prog_q.push_back(32'hA000_0000 + 32'(i));
    we0 = we_total; d0 = done_total;
    start_load(64'h0);
    stream(12, 1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    check("t1 writes", 64'(we_total - we0), 64'd12);
    check("t1 last addr", last_addr, 64'h2C);
    check("t1 last data", 64'(last_data), 64'hA000_000B);
    check("t1 release delay", 64'(rise_cyc - last_we_cyc), 64'd3);
    check("t1 done pulses", 64'(done_total - d0), 64'd1);
    check("t1 startpc", startpc, 64'h0);
    check("t1 proc_resetl", proc_resetl, 1'b1);
    check("t1 busy", busy, 1'b0);

    // Same program at 0x40 with a gap after every word; reload from RUN.
    we0 = we_total; d0 = done_total;
    start_load(64'h40);
    check("t2 held in reset", proc_resetl, 1'b0);
    stream(12, 1'b1, 1'b1);
    repeat (8) @(negedge CLK);
    check("t2 writes", 64'(we_total - we0), 64'd12);
    check("t2 last addr", last_addr, 64'h6C);
    check("t2 release delay", 64'(rise_cyc - last_we_cyc), 64'd3);
    check("t2 done pulses", 64'(done_total - d0), 64'd1);
    check("t2 startpc", startpc, 64'h40);

    // Misaligned base from RUN: error, core back in reset, nothing written.
    we0 = we_total;
    start_load(64'h2);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    @(negedge CLK);
    check("t3 err", err, 1'b1);
    check("t3 proc_resetl", proc_resetl, 1'b0);
    check("t3 in_ready", in_ready, 1'b0);
    check("t3 writes", 64'(we_total - we0), 64'd0);

    // 64 words, no last: overflow.
    prog_q.delete();
    for (int i = 0; i < MAX_WORDS; i++) prog_q.push_back(32'h0C00_0000 + 32'(i * 3));
    we0 = we_total;
    start_load(64'h100);
    check("t4 err cleared", err, 1'b0);
    stream(MAX_WORDS, 1'b0, 1'b0);
    check("t4 in_ready", in_ready, 1'b0);
    check("t4 err", err, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (4) @(negedge CLK);
    in_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("t4 writes", 64'(we_total - we0), 64'd64);
    check("t4 last addr", last_addr, 64'h1FC);
    check("t4 proc_resetl", proc_resetl, 1'b0);
    check("t4 busy", busy, 1'b0);

    // Asynchronous reset after five beats.
    prog_q.delete();
    for (int i = 0; i < 8; i++) prog_q.push_back(32'h5000_0000 + 32'(i));
    start_load(64'h200);
    check("t5 err cleared", err, 1'b0);
    stream(5, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = prog_q[5];
    #2 resetl = 1'b0;
    #1;
    check("t5 rst imem_we", imem_we, 1'b0);
    check("t5 rst imem_addr", imem_addr, 64'h0);
    check("t5 rst in_ready", in_ready, 1'b0);
    check("t5 rst busy", busy, 1'b0);
    check("t5 rst proc_resetl", proc_resetl, 1'b0);
    check("t5 rst startpc", startpc, 64'h0);
    check("t5 rst checksum", checksum, 64'h0);
    we0 = we_total;
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    resetl = 1'b1;
    repeat (3) @(negedge CLK);
    check("t5 no writes", 64'(we_total - we0), 64'd0);

    // Fresh load after reset; checksum wraps: 1 + 2 + 0xFFFFFFFF = 2.
    prog_q.delete();
    prog_q.push_back(32'h1);
    prog_q.push_back(32'h2);
    prog_q.push_back(32'hFFFF_FFFF);
    we0 = we_total; d0 = done_total;
    start_load(64'h300);
    stream(3, 1'b0, 1'b1);
    repeat (8) @(negedge CLK);
    check("t6 writes", 64'(we_total - we0), 64'd3);
    check("t6 last addr", last_addr, 64'h308);
    check("t6 done pulses", 64'(done_total - d0), 64'd1);
    check("t6 proc_resetl", proc_resetl, 1'b1);
    check("t6 startpc", startpc, 64'h300);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("t6 checksum", checksum, 64'h2);
`else
    check("t6 checksum", checksum, 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Synthesizable program loader that sits in front of the single-cycle processor's instruction memory.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive word addresses.
- Holds the processor in reset while loading. Then releases it with the configured start PC.
- Replaces bench-driven Reset_L/startPC sequencing with a hardware writer for the memory the core reads.

Parameters:
- ADDR_W, 6, log2 of instruction-memory depth in words (MAX_WORDS = 2^ADDR_W = 64)
- DATA_W, 32, instruction word width
- HOLD_CYC, 2, cycles proc_resetl stays low after the final write before release

Ports:
- CLK  input  1  system clock, rising edge
- resetl  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle pulse: begin a load session
- load_base  input  64  byte address of first word; sampled on load_start
- in_valid  input  1  stream word valid
- in_data  input  DATA_W  stream word
- in_last  input  1  marks final word of program
- in_ready  output  1  loader can accept a word this cycle
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  64  byte write address
- imem_wdata  output  DATA_W  write data
- proc_resetl  output  1  active-low reset to processor (drives its resetl)
- startpc  output  64  start PC to processor
- busy  output  1  high in LOAD or HOLD
- done  output  1  one-cycle pulse on release of proc_resetl
- err  output  1  sticky error flag, cleared by next accepted load_start
- checksum  output  32  see Optional Feature

Behaviour:
- Reset (async, resetl=0):
  - state=IDLE.
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - proc_resetl=0: the processor is held in reset from power-up.
  - startpc=0, busy=0, done=0, err=0, checksum=0, word count=0.
- States IDLE, LOAD, HOLD, RUN. All outputs are registered.
- IDLE / RUN, load_start=1:
  - If load_base[1:0]!=0: err<=1, go to IDLE, proc_resetl<=0.
  - Otherwise: capture base, count<=0, err<=0, proc_resetl<=0, go to LOAD.
  - load_start is ignored in LOAD and HOLD.
- LOAD:
  - in_ready=1 while count<MAX_WORDS.
  - A beat transfers when in_valid & in_ready.
  - The next cycle drives imem_we=1, imem_addr=base+4*count, imem_wdata=in_data (1-cycle latency).
  - count increments per beat.
  - Address arithmetic is 64-bit, modulo 2^64.
- LOAD, beat with in_last=1: write it, then go to HOLD.
- LOAD overflow: count==MAX_WORDS without in_last seen:
  - in_ready<=0, err<=1, go to IDLE.
  - proc_resetl stays 0 and no further writes occur.
- HOLD:
  - proc_resetl stays 0 for HOLD_CYC cycles after the final imem_we cycle.
  - Then proc_resetl<=1, startpc<=base, done=1 for one cycle, go to RUN.
- RUN:
  - proc_resetl=1, startpc stable, in_ready=0.
  - A new valid load_start re-enters LOAD with proc_resetl<=0 in the same edge.
- Other rules:
  - imem_we is never high outside the cycle following an accepted beat.
  - in_valid without in_ready has no effect.
  - Reset mid-LOAD/HOLD aborts immediately: no partial write after reset assertion, processor held in reset.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined: checksum accumulates the 32-bit wrap-around sum of accepted in_data words. It is cleared on accepted load_start and holds its value in HOLD/RUN.
- Undefined: checksum is tied to 0 and no adder is instantiated.

Test Plan:
- Load 12 words 0xA0000000+i at base 0, in_valid continuous, last on word 11:
  - 12 imem_we pulses at addresses 0x00..0x2C with matching data.
  - proc_resetl low until 2 cycles after the last write, then high.
  - startpc=0, done pulses once, busy falls.
- Same program at base 0x40 with in_valid deasserted every other cycle:
  - Addresses 0x40..0x6C, no write during gap cycles, identical release timing relative to the last write.
- Stream 64 words with no in_last:
  - After 64 writes, in_ready=0, err=1, proc_resetl stays 0, state IDLE.
  - A 65th in_valid causes no write.
- load_start with load_base=0x2: err=1, no writes, proc_resetl=0, in_ready=0.
- Assert resetl=0 after 5 beats:
  - All outputs return to reset values asynchronously.
  - No further imem_we.
  - A fresh load then completes normally.
- With PROG_LOADER_CHECKSUM_EN, words 1,2,0xFFFFFFFF: checksum=0x00000002 after done. Without the macro, checksum=0.
